// File: rtl/pcg_permute_pipe_pkg.sv
// ---------------------------------------------------------------------------
// pcg_pkg
// Shared definitions for the PCG output-permutation pipeline:
//   - mode encodings carried alongside each beat
//   - default widths / xorshift distance used by the top and its interface
//   - rotr_f: reference rotate-right at the default output width
// Optional feature macro used by the top: PCG_PERMUTE_STATS_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package pcg_pkg;

   localparam logic PCG_MODE_XSHRR = 1'b0;   // xorshift + data-dependent rotate
   localparam logic PCG_MODE_XSH   = 1'b1;   // xorshift only (debug/bypass)

   localparam int PCG_STATE_W_DEF = 128;
   localparam int PCG_OUT_W_DEF   = 64;
   localparam int PCG_XSHIFT_DEF  = 6;

   // Width wrapper for rotr_f; the function is bound to this width.
   localparam int PCG_ROTR_W   = PCG_OUT_W_DEF;
   localparam int PCG_ROTR_A_W = $clog2(PCG_ROTR_W);

   function automatic logic [PCG_ROTR_W-1:0] rotr_f(
      input logic [PCG_ROTR_W-1:0]   value,
      input logic [PCG_ROTR_A_W-1:0] amount
   );
      logic [2*PCG_ROTR_W-1:0] dbl;
      dbl = {value, value} >> amount;
      return dbl[PCG_ROTR_W-1:0];
   endfunction

endpackage

// File: rtl/pcg_permute_pipe_if.sv
// ---------------------------------------------------------------------------
// pcg_permute_pipe_if
// Valid/ready stream bundle for the permutation pipe.
//   in_valid/in_ready/in_data/in_mode : LCG state words in
//   out_valid/out_ready/out_data      : permuted words out
// Modports: master (producer/consumer side), slave (the pipe).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface pcg_permute_pipe_if
   import pcg_pkg::*;
#(
   parameter int STATE_W = PCG_STATE_W_DEF,
   parameter int OUT_W   = PCG_OUT_W_DEF
);
   logic               in_valid;
   logic               in_ready;
   logic [STATE_W-1:0] in_data;
   logic               in_mode;
   logic               out_valid;
   logic               out_ready;
   logic [OUT_W-1:0]   out_data;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pcg_permute_pipe_rotr.sv
// ---------------------------------------------------------------------------
// pcg_rotr
// Combinational barrel rotate-right, one mux layer per amount bit.
//   i_value  [W-1:0]       word to rotate
//   i_amount [log2(W)-1:0] rotate distance (0 passes the word unchanged)
//   o_value  [W-1:0]       rotated word
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module pcg_rotr #(
   parameter int W = 64,
   localparam int A_W = $clog2(W)
)(
   input  logic [W-1:0]   i_value,
   input  logic [A_W-1:0] i_amount,
   output logic [W-1:0]   o_value
);
   logic [W-1:0] w_stage [0:A_W];

   assign w_stage[0] = i_value;

   for (genvar k = 0; k < A_W; k++) begin : g_layer
      localparam int SH = 1 << k;
      assign w_stage[k+1] = i_amount[k] ? {w_stage[k][SH-1:0], w_stage[k][W-1:SH]}
                                        : w_stage[k];
   end

   assign o_value = w_stage[A_W];
endmodule

// File: rtl/pcg_permute_pipe.sv
// ---------------------------------------------------------------------------
// pcg_permute_pipe
// PCG output permutation: xorshift, truncate, data-dependent rotate-right.
// Two register stages with valid/ready flow control and full backpressure.
//   clk        clock
//   rst        synchronous active-low reset
//   bus        pcg_permute_pipe_if.slave (in_* stream in, out_* stream out)
//   out_count  [31:0] completed output transfers     (PCG_PERMUTE_STATS_EN)
//   mode1_seen [0:0]  sticky: a mode-1 beat completed (PCG_PERMUTE_STATS_EN)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module pcg_permute_pipe
   import pcg_pkg::*;
#(
   parameter int STATE_W = PCG_STATE_W_DEF,
   parameter int OUT_W   = PCG_OUT_W_DEF,
   parameter int XSHIFT  = PCG_XSHIFT_DEF
)(
   input  logic              clk,
   input  logic              rst,
   pcg_permute_pipe_if.slave bus
`ifdef PCG_PERMUTE_STATS_EN
   ,
   output logic [31:0]       out_count,
   output logic [0:0]        mode1_seen
`endif
);
   localparam int ROT_W = $clog2(OUT_W);

   if (STATE_W < OUT_W + ROT_W) begin : g_bad_width
      $error("pcg_permute_pipe: STATE_W must be >= OUT_W + log2(OUT_W)");
   end
   if ((OUT_W < 8) || ((OUT_W & (OUT_W - 1)) != 0)) begin : g_bad_out_w
      $error("pcg_permute_pipe: OUT_W must be a power of two >= 8");
   end
   if ((XSHIFT < 1) || (XSHIFT >= STATE_W)) begin : g_bad_xshift
      $error("pcg_permute_pipe: XSHIFT must be in [1, STATE_W)");
   end

   // Whole pipe advances together; only a stalled, full output stage blocks it.
   logic w_en;
   assign w_en         = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = w_en;

   // ---- stage 0 -> 1: xorshift, truncate, capture rotate field ----
   logic signed [STATE_W-1:0] w_x_p0;
   logic [OUT_W-1:0]          w_t_p0;
   logic [ROT_W-1:0]          w_rot_p0;

   assign w_x_p0   = bus.in_data ^ (bus.in_data >> XSHIFT);
   assign w_t_p0   = w_x_p0[STATE_W-ROT_W-1 -: OUT_W];
   // Rotate amount comes from the raw state, not the xorshifted word.
   assign w_rot_p0 = bus.in_data[STATE_W-1 -: ROT_W];

   logic             r_vld_p1;
   logic [OUT_W-1:0] r_t_p1;
   logic [ROT_W-1:0] r_rot_p1;
   logic             r_mode_p1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_vld_p1  <= 1'b0;
         r_t_p1    <= '0;
         r_rot_p1  <= '0;
         r_mode_p1 <= PCG_MODE_XSHRR;
      end else if (w_en) begin
         r_vld_p1 <= bus.in_valid;
         if (bus.in_valid) begin
            r_t_p1    <= w_t_p0;
            r_rot_p1  <= w_rot_p0;
            r_mode_p1 <= bus.in_mode;
         end
      end
   end

   // ---- stage 1 -> 2: rotate (bypassed in XSH mode by forcing amount 0) ----
   logic [ROT_W-1:0] w_amt_p1;
   logic [OUT_W-1:0] w_res_p1;

   assign w_amt_p1 = (r_mode_p1 == PCG_MODE_XSH) ? '0 : r_rot_p1;

   pcg_rotr #(.W(OUT_W)) u_rotr (
      .i_value  (r_t_p1),
      .i_amount (w_amt_p1),
      .o_value  (w_res_p1)
   );

   logic             r_vld_p2;
   logic [OUT_W-1:0] r_data_p2;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_vld_p2  <= 1'b0;
         r_data_p2 <= '0;
      end else if (w_en) begin
         r_vld_p2 <= r_vld_p1;
         if (r_vld_p1) begin
            r_data_p2 <= w_res_p1;
         end
      end
   end

   assign bus.out_valid = r_vld_p2;
   assign bus.out_data  = r_data_p2;

`ifdef PCG_PERMUTE_STATS_EN
   logic        r_mode_p2;
   logic [31:0] r_out_count;
   logic        r_mode1_seen;
   logic        w_done_p2;

   assign w_done_p2 = r_vld_p2 && bus.out_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_mode_p2    <= PCG_MODE_XSHRR;
         r_out_count  <= '0;
         r_mode1_seen <= 1'b0;
      end else begin
         if (w_en && r_vld_p1) begin
            r_mode_p2 <= r_mode_p1;
         end
         if (w_done_p2) begin
            r_out_count <= r_out_count + 32'd1;
            if (r_mode_p2 == PCG_MODE_XSH) begin
               r_mode1_seen <= 1'b1;
            end
         end
      end
   end

   assign out_count  = r_out_count;
   assign mode1_seen = r_mode1_seen;
`endif
endmodule
